// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier, one recode/add/shift step per clock, signed or unsigned operands.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy.
module seq_booth_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] y
);

   // One guard bit lets unsigned operands run through the signed Booth datapath.
   localparam int E  = WIDTH + 1;
   localparam int CW = $clog2(E + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [E-1:0]    m;
   logic [E-1:0]    p_hi;
   logic [E-1:0]    q;
   logic            q_m1;
   logic [CW-1:0]   cnt;

   logic [E-1:0]    a_ext;
   logic [E-1:0]    b_ext;
   logic [E-1:0]    sum;
   logic [E-1:0]    p_nxt;
   logic [E-1:0]    q_nxt;

   assign a_ext = {signed_mode & a[WIDTH-1], a};
   assign b_ext = {signed_mode & b[WIDTH-1], b};

   always_comb begin
      sum = p_hi;
      case ({q[0], q_m1})
         2'b01:   sum = p_hi + m;
         2'b10:   sum = p_hi - m;
         default: sum = p_hi;
      endcase
      p_nxt = {sum[E-1], sum[E-1:1]};
      q_nxt = {sum[0], q[E-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         m     <= '0;
         p_hi  <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         y     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  m     <= a_ext;
                  p_hi  <= '0;
                  q     <= b_ext;
                  q_m1  <= 1'b0;
                  cnt   <= CW'(E);
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               p_hi <= p_nxt;
               q    <= q_nxt;
               q_m1 <= q[0];
               cnt  <= cnt - 1'b1;
               // Last step: low 2*WIDTH bits of the shifted {P_hi,Q} are the product.
               if (cnt == CW'(1)) begin
                  y     <= {sum[WIDTH-1:1], q_nxt};
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Bench for seq_booth_multiplier: WIDTH=4 and WIDTH=8 instances, expected products queued at issue.
module tb_seq_booth_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, start4, sm4, busy4, done4;
   logic [3:0] a4, b4;
   logic [7:0] y4;

   logic        rst8, start8, sm8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] y8;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]  q4[$];
   logic [15:0] q8[$];

   seq_booth_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .y(y4)
   );

   seq_booth_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .y(y8)
   );

   function automatic logic [7:0] ref4(input logic sm, input logic [3:0] x, input logic [3:0] z);
      logic signed [4:0] ex;
      logic signed [4:0] ez;
      logic signed [9:0] pr;
      ex = {sm & x[3], x};
      ez = {sm & z[3], z};
      pr = ex * ez;
      return pr[7:0];
   endfunction

   // Pulse start for one edge, then scramble the operand inputs.
   task automatic issue4(input logic sm, input logic [3:0] x, input logic [3:0] z);
      sm4 = sm; a4 = x; b4 = z; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
   endtask

   task automatic wait4(output logic [7:0] yo, output int lat, output int bcnt);
      lat = -1; bcnt = 0; yo = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (busy4) bcnt++;
         if (done4) begin lat = i; yo = y4; break; end
      end
   endtask

   task automatic issue8(input logic sm, input logic [7:0] x, input logic [7:0] z);
      sm8 = sm; a8 = x; b8 = z; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
   endtask

   task automatic wait8(output logic [15:0] yo, output int lat);
      lat = -1; yo = '0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (done8) begin lat = i; yo = y8; break; end
      end
   endtask

   task automatic test_reset();
      rst4 = 1'b1; rst8 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy4, done4, y4} !== 10'b0) begin
         n_fail++; $display("FAIL reset_w4: busy/done/y=%b/%b/%h required 0/0/00", busy4, done4, y4);
      end
      n_cmp++;
      if ({busy8, done8, y8} !== 18'b0) begin
         n_fail++; $display("FAIL reset_w8: busy/done/y=%b/%b/%h required 0/0/0000", busy8, done8, y8);
      end
      rst4 = 1'b0; rst8 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_signed_latency();
      logic [7:0] yo; logic [7:0] exp; int lat; int bcnt;
      q4.push_back(8'hF4);
      issue4(1'b1, 4'd3, 4'hC);
      n_cmp++;
      if (busy4 !== 1'b1) begin
         n_fail++; $display("FAIL busy_after_start: busy=%b required 1", busy4);
      end
      wait4(yo, lat, bcnt);
      exp = q4.pop_front();
      n_cmp++;
      if (lat !== 5) begin n_fail++; $display("FAIL latency_w4: got %0d cycles required 5", lat); end
      n_cmp++;
      if (bcnt !== 4) begin n_fail++; $display("FAIL busy_span: busy high %0d samples before done required 4", bcnt); end
      n_cmp++;
      if (busy4 !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: busy=%b required 0", busy4); end
      n_cmp++;
      if (yo !== exp) begin n_fail++; $display("FAIL signed_3x-4: y=%h required %h", yo, exp); end
      @(posedge clk); #1;
      n_cmp++;
      if (done4 !== 1'b0 || y4 !== exp) begin
         n_fail++; $display("FAIL done_pulse_width: done=%b y=%h required 0 and %h", done4, y4, exp);
      end
   endtask

   task automatic test_patterns();
      logic [16:0] tbl [4] = '{{1'b0, 4'hF, 4'hF, 8'hE1}, {1'b1, 4'hF, 4'hF, 8'h01},
                               {1'b1, 4'h8, 4'h8, 8'h40}, {1'b0, 4'h0, 4'h0, 8'h00}};
      logic [7:0] yo; logic [7:0] exp; int lat; int bcnt;
      for (int i = 0; i < 4; i++) begin
         q4.push_back(tbl[i][7:0]);
         issue4(tbl[i][16], tbl[i][15:12], tbl[i][11:8]);
         wait4(yo, lat, bcnt);
         exp = q4.pop_front();
         n_cmp++;
         if (lat !== 5 || yo !== exp) begin
            n_fail++; $display("FAIL pattern_%0d: y=%h lat=%0d required %h lat=5", i, yo, lat, exp);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [7:0] yo; logic [7:0] exp; int lat; int bcnt; int extra;
      q4.push_back(8'hCF);
      issue4(1'b1, 4'h7, 4'h9);
      repeat (2) begin @(posedge clk); #1; end
      sm4 = 1'b0; a4 = 4'h2; b4 = 4'h2; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      wait4(yo, lat, bcnt);
      exp = q4.pop_front();
      n_cmp++;
      if (lat !== 2 || yo !== exp) begin
         n_fail++; $display("FAIL start_ignored: y=%h lat=%0d required %h lat=2", yo, lat, exp);
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done4) extra++; end
      n_cmp++;
      if (extra !== 0) begin n_fail++; $display("FAIL no_second_result: %0d done pulses required 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] yo; logic [7:0] exp; int lat; int bcnt;
      q4.push_back(8'h0F);
      q4.push_back(8'hFA);
      issue4(1'b0, 4'd3, 4'd5);
      wait4(yo, lat, bcnt);
      exp = q4.pop_front();
      n_cmp++;
      if (yo !== exp) begin n_fail++; $display("FAIL b2b_first: y=%h required %h", yo, exp); end
      issue4(1'b1, 4'hE, 4'h3);
      n_cmp++;
      if (done4 !== 1'b0 || busy4 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_accept: done=%b busy=%b required 0 1", done4, busy4);
      end
      wait4(yo, lat, bcnt);
      exp = q4.pop_front();
      n_cmp++;
      if (lat !== 5 || yo !== exp) begin
         n_fail++; $display("FAIL b2b_second: y=%h lat=%0d required %h lat=5", yo, lat, exp);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      issue4(1'b1, 4'h5, 4'h3);
      repeat (2) begin @(posedge clk); #1; end
      rst4 = 1'b1;
      @(posedge clk); #1;
      rst4 = 1'b0;
      n_cmp++;
      if ({busy4, done4, y4} !== 10'b0) begin
         n_fail++; $display("FAIL reset_mid: busy/done/y=%b/%b/%h required 0/0/00", busy4, done4, y4);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done4 || busy4) pulses++; end
      n_cmp++;
      if (pulses !== 0) begin n_fail++; $display("FAIL reset_abort: %0d busy/done cycles required 0", pulses); end
   endtask

   task automatic test_width8();
      logic [24:0] tbl [3] = '{{1'b1, 8'h80, 8'h80, 8'h00}, {1'b0, 8'hFF, 8'hFF, 8'h00},
                               {1'b1, 8'hFF, 8'hFF, 8'h00}};
      logic [15:0] exps [3] = '{16'h4000, 16'hFE01, 16'h0001};
      logic [15:0] yo; logic [15:0] exp; int lat;
      for (int i = 0; i < 3; i++) begin
         q8.push_back(exps[i]);
         issue8(tbl[i][24], tbl[i][23:16], tbl[i][15:8]);
         wait8(yo, lat);
         exp = q8.pop_front();
         n_cmp++;
         if (lat !== 9 || yo !== exp) begin
            n_fail++; $display("FAIL w8_case_%0d: y=%h lat=%0d required %h lat=9", i, yo, lat, exp);
         end
      end
   endtask

   task automatic test_sweep();
      logic [7:0] yo; logic [7:0] exp; int lat; int bcnt;
      for (int s = 0; s < 2; s++) begin
         for (int x = 0; x < 16; x++) begin
            for (int z = 0; z < 16; z++) begin
               q4.push_back(ref4(1'(s), 4'(x), 4'(z)));
               issue4(1'(s), 4'(x), 4'(z));
               wait4(yo, lat, bcnt);
               exp = q4.pop_front();
               n_cmp++;
               if (lat !== 5 || yo !== exp) begin
                  n_fail++;
                  $display("FAIL sweep s=%0d a=%h b=%h: y=%h lat=%0d required %h lat=5", s, x, z, yo, lat, exp);
               end
            end
         end
      end
   endtask

   initial begin
      rst4 = 1'b1; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
      rst8 = 1'b1; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      test_reset();
      test_signed_latency();
      test_patterns();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
